// File: rtl/router_dest_port_if.sv
// router_dest_port_if: byte push/pop bus between router core, reader and one destination port
//   write_enb/data_in   core -> port push request and byte
//   read_enb            reader -> port pop request
//   data_out            port -> reader registered popped byte
//   vld_out/full/empty  port status flags
//   soft_reset          port one-cycle timeout flush pulse
interface router_dest_port_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             vld_out;
    logic             full;
    logic             empty;
    logic             soft_reset;

    modport master (
        output write_enb, data_in, read_enb,
        input  data_out, vld_out, full, empty, soft_reset
    );

    modport slave (
        input  write_enb, data_in, read_enb,
        output data_out, vld_out, full, empty, soft_reset
    );
endinterface

// File: rtl/router_dest_port.sv
// router_dest_port: destination-port byte FIFO with reader timeout flush
//   clock   single clock, all state on posedge
//   resetn  asynchronous active-low reset
//   bus     slave side of router_dest_port_if (push, pop, data_out, flags, soft_reset)
module router_dest_port #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic               clock,
    input  logic               resetn,
    router_dest_port_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_soft_reset;
    logic [TW-1:0]    r_tcnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_flush;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_push  = bus.write_enb && !w_full;
    assign w_pop   = bus.read_enb && !w_empty;
    // reader has left a byte unread for TIMEOUT consecutive cycles
    assign w_flush = !w_empty && !bus.read_enb && r_tcnt == TW'(TIMEOUT - 1);

    assign bus.data_out   = r_data_out;
    assign bus.vld_out    = !w_empty;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.soft_reset = r_soft_reset;

    // storage needs no reset; a push on the flush edge is dropped
    always_ff @(posedge clock) begin
        if (w_push && !w_flush)
            r_mem[r_wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_soft_reset <= 1'b0;
            r_tcnt       <= '0;
        end else begin
            r_soft_reset <= w_flush;
            if (w_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_data_out <= '0;
                r_tcnt     <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop) begin
                    r_data_out <= r_mem[r_rd_ptr];
                    r_rd_ptr   <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
                r_tcnt  <= (w_empty || bus.read_enb) ? '0 : r_tcnt + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_dest_port.sv
// tb_router_dest_port: scoreboard bench for router_dest_port
module tb_router_dest_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] sb [$];
    logic [7:0] last_exp = 8'h00;

    router_dest_port_if #(.WIDTH(8)) bus ();

    router_dest_port #(.DEPTH(16), .WIDTH(8), .TIMEOUT(30)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: a pop is due whenever read_enb meets a non-empty expected FIFO
    initial begin
        logic do_pop, do_idle;
        forever begin
            @(posedge clk);
            do_pop  = rst_n && bus.read_enb && sb.size() > 0;
            do_idle = rst_n && bus.read_enb && sb.size() == 0;
            #1;
            if (do_pop) begin
                last_exp = sb.pop_front();
                check("pop_data", 32'(bus.data_out), 32'(last_exp));
            end else if (do_idle) begin
                check("pop_empty_hold", 32'(bus.data_out), 32'(last_exp));
            end
        end
    end

    // one clock of stimulus; acc is the hand-computed push acceptance
    task automatic step(input logic we, input logic [7:0] d, input logic re, input logic acc);
        @(negedge clk);
        bus.write_enb = we;
        bus.data_in   = d;
        bus.read_enb  = re;
        @(posedge clk);
        #2;
        if (acc) sb.push_back(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] vec [3];
        vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'hFF;
        bus.write_enb = 1'b0;
        bus.data_in   = 8'h00;
        bus.read_enb  = 1'b0;
        #12;
        check("reset_empty", 32'(bus.empty), 32'd1);
        check("reset_vld", 32'(bus.vld_out), 32'd0);
        check("reset_full", 32'(bus.full), 32'd0);
        check("reset_soft", 32'(bus.soft_reset), 32'd0);
        rst_n = 1'b1;

        // order and latency
        for (int i = 0; i < 3; i++) step(1'b1, vec[i], 1'b0, 1'b1);
        check("vld_after_push", 32'(bus.vld_out), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("vld_before_last", 32'(bus.vld_out), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("vld_after_drain", 32'(bus.vld_out), 32'd0);
        check("empty_after_drain", 32'(bus.empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // full and overflow drop
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            if (i == 14) check("not_full_15", 32'(bus.full), 32'd0);
        end
        check("full_16", 32'(bus.full), 32'd1);
        step(1'b1, 8'h10, 1'b0, 1'b0);
        check("full_after_drop", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("empty_after_full_drain", 32'(bus.empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // simultaneous push/pop at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h25 + 8'(i), 1'b1, 1'b1);
            check("simul_vld", 32'(bus.vld_out), 32'd1);
            check("simul_full", 32'(bus.full), 32'd0);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("simul_drained", 32'(bus.empty), 32'd1);

        // push on empty with concurrent read: no read-through
        step(1'b1, 8'h99, 1'b1, 1'b1);
        check("no_readthrough", 32'(bus.data_out), 32'(last_exp));
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // timeout flush
        step(1'b1, 8'h77, 1'b0, 1'b1);
        for (int i = 1; i < 30; i++) begin
            idle(1);
            check("to_no_soft", 32'(bus.soft_reset), 32'd0);
        end
        check("to_still_vld", 32'(bus.vld_out), 32'd1);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        check("to_soft", 32'(bus.soft_reset), 32'd1);
        check("to_empty", 32'(bus.empty), 32'd1);
        check("to_dout_zero", 32'(bus.data_out), 32'd0);
        sb.delete();
        last_exp = 8'h00;
        idle(1);
        check("to_pulse_end", 32'(bus.soft_reset), 32'd0);
        check("to_push_dropped", 32'(bus.empty), 32'd1);

        // read pulse at cycle 29 prevents the flush
        step(1'b1, 8'h55, 1'b0, 1'b1);
        idle(28);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("rd29_no_soft", 32'(bus.soft_reset), 32'd0);
            idle(1);
        end
        check("rd29_empty", 32'(bus.empty), 32'd1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_reset_dout", 32'(bus.data_out), 32'hC0);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_empty", 32'(bus.empty), 32'd1);
        check("areset_vld", 32'(bus.vld_out), 32'd0);
        check("areset_dout", 32'(bus.data_out), 32'd0);
        sb.delete();
        last_exp = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_reset_empty", 32'(bus.empty), 32'd1);

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
